alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles from operands on alu_a/alu_b/alu_sel to a valid alu_out (registered ALU).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, min 2), meaning response buffer entries.
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  host command valid
  cmd_ready  out  1  driver can accept a command
  cmd_a  in  16  operand A
  cmd_b  in  16  operand B
  cmd_sel  in  4  ALU operation select
  cmd_tag  in  4  host tag returned with result
  alu_a  out  16  operand A to ALU
  alu_b  out  16  operand B to ALU
  alu_sel  out  4  operation select to ALU
  alu_out  in  16  ALU result
  rsp_valid  out  1  response valid
  rsp_ready  in  1  host accepts response
  rsp_data  out  16  captured ALU result
  rsp_tag  out  4  tag of that result
  busy  out  1  commands in flight or buffered

Function
REQ-004 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both 1.
REQ-005 SHALL register cmd_a/cmd_b/cmd_sel onto alu_a/alu_b/alu_sel at the accept edge k; alu_* SHALL hold the last issued values when no command is accepted.
REQ-006 SHALL carry valid+tag through an ALU_LAT+1 stage delay line and write alu_out with that tag into the response FIFO at edge k+ALU_LAT+1.
REQ-007 SHALL make rsp_valid = FIFO not empty, with rsp_data/rsp_tag from the FIFO head; minimum accept-to-rsp_valid latency is ALU_LAT+1 cycles.
REQ-008 SHALL pop the FIFO on an edge where rsp_valid and rsp_ready are both 1; rsp_data/rsp_tag SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-009 SHALL return responses in command-acceptance order; one command per cycle sustained when rsp_ready=1.
REQ-010 SHALL drive cmd_ready = (inflight + fifo_count) < FIFO_DEPTH, computed from registered state only; a pop SHALL NOT raise cmd_ready in the same cycle.
REQ-011 SHALL never drop or overwrite a result; FIFO write when full is impossible by REQ-010 and SHALL be an assertion.
REQ-012 SHALL handle simultaneous FIFO push and pop in one edge, count unchanged, pointers wrapping modulo FIFO_DEPTH.
REQ-013 SHALL drive busy = (inflight != 0) or (fifo_count != 0).
REQ-014 SHALL pass alu_out through unchanged; 16-bit wrap-around is the ALU's, no saturation or width change.

Reset
REQ-015 SHALL, while rst=0, immediately force: alu_a=0, alu_b=0, alu_sel=0, rsp_valid=0, busy=0, cmd_ready=0, delay line cleared, FIFO pointers and count 0.
REQ-016 SHALL discard all in-flight and buffered results on reset mid-operation; no stale response after release.
REQ-017 SHALL drive cmd_ready=1 on the first cycle after rst deasserts.

Structure
REQ-018 SHALL take ALU_W=16, SEL_W=4, TAG_W=4 and the opcode enum (ADD, SUB, AND, OR, XOR, ...) from shared package alu_pkg, also used by alu and the test program.
REQ-019 SHALL implement the response buffer as sub-module alu_rsp_fifo (synchronous, one clock, same async active-low reset, push/pop/full/empty/count).

Verification
REQ-020 Single ADD a=16'h0003 b=16'h0004 tag=5, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_data=16'h0007, rsp_tag=5.
REQ-021 Four back-to-back commands tags 0..3, rsp_ready=0 -> cmd_ready=0 after 4th accept, 5th stalls; raise rsp_ready -> tags 0,1,2,3 in order, then 5th accepted.
REQ-022 SUB a=16'h0000 b=16'h0001 -> rsp_data=16'hFFFF.
REQ-023 Full FIFO, cmd_valid=1, single pop -> cmd_ready stays 0 that cycle, 1 next cycle; no lost or duplicated tag.
REQ-024 rst=0 asserted with 2 commands in flight -> rsp_valid=0, busy=0 immediately; after release no response appears until new command.
REQ-025 rsp_ready toggling 1/0 with 8 random commands -> data/tag stable during stalls; all 8 results match reference model in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and the reference ALU operation for the ALU driver slice.
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int SEL_W = 4;
  localparam int TAG_W = 4;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_NOT = 4'd7
  } alu_op_e;

  // One slot of the latency-matching delay line: valid plus host tag.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } slot_t;

  function automatic logic [ALU_W-1:0] alu_compute(input logic [SEL_W-1:0] sel,
                                                   input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] res;
    case (sel)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[3:0];
      OP_SHR:  res = a >> b[3:0];
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response buffer: synchronous FIFO with power-of-two depth, head visible on rdata.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ALU_W + TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read unless count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/alu_driver.sv
// Issues host commands to a registered ALU, matches its latency with a tag delay
// line and buffers results in order for a valid/ready response port.
module alu_driver
  import alu_pkg::*;
#(
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [ALU_W-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int STAGES = ALU_LAT + 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + STAGES + 1) + 1;

  slot_t            pipe_q [STAGES];
  slot_t            pipe_d [STAGES];
  logic [ALU_W-1:0] alu_a_q, alu_a_d;
  logic [ALU_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;

  logic                   accept, push, pop;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [ALU_W+TAG_W-1:0] fifo_rdata;
  logic [OCC_W-1:0]       inflight, occupancy;

  // Credit check uses only registered occupancy, so a pop frees a slot one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + OCC_W'(pipe_q[i].valid);
    occupancy = inflight + OCC_W'(fifo_count);
    cmd_ready = rst && (occupancy < OCC_W'(FIFO_DEPTH));
    busy      = (inflight != '0) || (fifo_count != '0);
  end

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    alu_a_d   = accept ? cmd_a   : alu_a_q;
    alu_b_d   = accept ? cmd_b   : alu_b_q;
    alu_sel_d = accept ? cmd_sel : alu_sel_q;
    pipe_d    = pipe_q;
    pipe_d[0] = '{valid: accept, tag: cmd_tag};
    for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      pipe_q    <= '{default: '0};
    end else begin
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      pipe_q    <= pipe_d;
    end
  end

  // The last delay stage lines up with alu_out being valid for that command.
  assign push      = pipe_q[ALU_LAT].valid;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;

  alu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ALU_W + TAG_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({alu_out, pipe_q[ALU_LAT].tag}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {rsp_data, rsp_tag} = fifo_rdata;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;

  assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a registered one-cycle ALU model attached.
module tb_alu_driver;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ALU_W-1:0] cmd_a = '0;
  logic [ALU_W-1:0] cmd_b = '0;
  logic [SEL_W-1:0] cmd_sel = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [ALU_W-1:0] alu_a, alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [ALU_W-1:0] alu_out = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [ALU_W-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [TAG_W-1:0] got_tag[$];
  logic [ALU_W-1:0] got_data[$];

  alu_driver #(.ALU_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .cmd_tag   (cmd_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) alu_out <= alu_compute(alu_sel, alu_a, alu_b);

  // Record the head if it will be popped on the coming edge, then advance one cycle.
  task automatic step();
    if (rst && rsp_valid && rsp_ready) begin
      got_tag.push_back(rsp_tag);
      got_data.push_back(rsp_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++; if ({alu_a, alu_b, alu_sel} !== '0) $display("[TB] FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL release_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_single_add();
    got_tag.delete(); got_data.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_sel = OP_ADD; cmd_tag = 4'd5;
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL add_ready: got %b want 1", cmd_ready); else n_pass++;
    step();
    cmd_valid = 1'b0; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_sel = OP_XOR;
    n_checks++; if ({alu_a, alu_b, alu_sel} !== {16'h0003, 16'h0004, 4'd0}) $display("[TB] FAIL add_alu_ops: got %h want 0003_0004_0", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL add_k0: got valid=%b busy=%b want valid=0 busy=1", rsp_valid, busy); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL add_k1_valid: got %b want 0", rsp_valid); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL add_k2_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0007 || rsp_tag !== 4'd5) $display("[TB] FAIL add_result: got data=%h tag=%0d want 0007 tag 5", rsp_data, rsp_tag); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL add_drained: got valid=%b busy=%b want 0 0", rsp_valid, busy); else n_pass++;
    n_checks++; if (alu_a !== 16'h0003) $display("[TB] FAIL add_alu_hold: got %h want 0003", alu_a); else n_pass++;
  endtask

  task automatic test_sub_wrap();
    int cyc;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 16'h0000; cmd_b = 16'h0001; cmd_sel = OP_SUB; cmd_tag = 4'd2;
    step();
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 8) begin step(); cyc++; end
    n_checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL sub_timeout: got valid=%b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'hFFFF || rsp_tag !== 4'd2) $display("[TB] FAIL sub_result: got data=%h tag=%0d want FFFF tag 2", rsp_data, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [ALU_W-1:0] exp_data;
    got_tag.delete(); got_data.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = 16'h0010; cmd_b = 16'(i); cmd_sel = OP_ADD; cmd_tag = 4'(i);
      n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready); else n_pass++;
      step();
    end
    cmd_a = 16'h0100; cmd_b = 16'h0001; cmd_tag = 4'd4;
    n_checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL b2b_full: got %b want 0", cmd_ready); else n_pass++;
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL b2b_stall: got ready=%b busy=%b want 0 1", cmd_ready, busy); else n_pass++;
    n_checks++; if (rsp_tag !== 4'd0 || rsp_data !== 16'h0010) $display("[TB] FAIL b2b_head: got tag=%0d data=%h want 0 0010", rsp_tag, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    n_checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL pop_same_cycle: got %b want 0", cmd_ready); else n_pass++;
    step();
    rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_tag !== 4'd1) $display("[TB] FAIL pop_next_cycle: got ready=%b tag=%0d want 1 1", cmd_ready, rsp_tag); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL b2b_refill: got %b want 0", cmd_ready); else n_pass++;
    rsp_ready = 1'b1;
    cyc = 0;
    while (got_tag.size() < 5 && cyc < 20) begin step(); cyc++; end
    n_checks++; if (got_tag.size() != 5) $display("[TB] FAIL b2b_count: got %0d want 5", got_tag.size()); else n_pass++;
    for (int i = 0; i < got_tag.size() && i < 5; i++) begin
      exp_data = (i < 4) ? 16'h0010 + 16'(i) : 16'h0101;
      n_checks++; if (got_tag[i] !== 4'(i) || got_data[i] !== exp_data) $display("[TB] FAIL b2b_order_%0d: got tag=%0d data=%h want tag=%0d data=%h", i, got_tag[i], got_data[i], i, exp_data); else n_pass++;
    end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL b2b_empty: got valid=%b busy=%b want 0 0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int cyc;
    got_tag.delete(); got_data.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_a = 16'h0001; cmd_b = 16'(i + 2); cmd_sel = OP_ADD; cmd_tag = 4'(i + 7);
      step();
    end
    cmd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) $display("[TB] FAIL mid_reset_now: got valid=%b busy=%b ready=%b want 0 0 0", rsp_valid, busy, cmd_ready); else n_pass++;
    n_checks++; if (alu_a !== 16'h0000) $display("[TB] FAIL mid_reset_alu_a: got %h want 0000", alu_a); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (got_tag.size() != 0 || rsp_valid !== 1'b0) $display("[TB] FAIL mid_no_stale: got %0d responses valid=%b want 0 0", got_tag.size(), rsp_valid); else n_pass++;
    cmd_valid = 1'b1; cmd_a = 16'h0001; cmd_b = 16'h0001; cmd_sel = OP_ADD; cmd_tag = 4'd9;
    step();
    cmd_valid = 1'b0;
    cyc = 0;
    while (got_tag.size() < 1 && cyc < 8) begin step(); cyc++; end
    n_checks++; if (got_tag.size() != 1) $display("[TB] FAIL mid_new_count: got %0d want 1", got_tag.size()); else n_pass++;
    if (got_tag.size() > 0) begin
      n_checks++; if (got_tag[0] !== 4'd9 || got_data[0] !== 16'h0002) $display("[TB] FAIL mid_new_result: got tag=%0d data=%h want 9 0002", got_tag[0], got_data[0]); else n_pass++;
    end
  endtask

  task automatic test_stall_toggle();
    logic [SEL_W-1:0] t_sel [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_XOR};
    logic [ALU_W-1:0] t_a   [8] = '{16'hFFFF, 16'h1234, 16'hF0F0, 16'h0F00, 16'hAAAA, 16'h7FFF, 16'h0005, 16'h1234};
    logic [ALU_W-1:0] t_b   [8] = '{16'h0002, 16'h0234, 16'h3C3C, 16'h00F0, 16'hFFFF, 16'h0001, 16'h0007, 16'h1234};
    logic [ALU_W-1:0] t_exp [8] = '{16'h0001, 16'h1000, 16'h3030, 16'h0FF0, 16'h5555, 16'h8000, 16'hFFFE, 16'h0000};
    int idx, cyc, stable_checks;
    logic fire, have_prev;
    logic [TAG_W-1:0] prev_tag;
    logic [ALU_W-1:0] prev_data;
    got_tag.delete(); got_data.delete();
    idx = 0; cyc = 0; have_prev = 1'b0; stable_checks = 0;
    prev_tag = '0; prev_data = '0;
    while (got_tag.size() < 8 && cyc < 80) begin
      rsp_ready = ((cyc % 2) == 0);
      if (have_prev && rsp_valid) begin
        stable_checks++;
        n_checks++; if (rsp_tag !== prev_tag || rsp_data !== prev_data) $display("[TB] FAIL stall_stable: got tag=%0d data=%h want tag=%0d data=%h", rsp_tag, rsp_data, prev_tag, prev_data); else n_pass++;
      end
      have_prev = rsp_valid && !rsp_ready;
      prev_tag  = rsp_tag;
      prev_data = rsp_data;
      if (idx < 8) begin
        cmd_valid = 1'b1; cmd_a = t_a[idx]; cmd_b = t_b[idx]; cmd_sel = t_sel[idx]; cmd_tag = 4'(idx + 8);
      end else begin
        cmd_valid = 1'b0;
      end
      fire = cmd_valid && cmd_ready;
      step();
      if (fire) idx++;
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    n_checks++; if (got_tag.size() != 8) $display("[TB] FAIL stall_count: got %0d want 8", got_tag.size()); else n_pass++;
    n_checks++; if (stable_checks == 0) $display("[TB] FAIL stall_observed: got %0d stalled cycles want >0", stable_checks); else n_pass++;
    for (int i = 0; i < got_tag.size() && i < 8; i++) begin
      n_checks++; if (got_tag[i] !== 4'(i + 8) || got_data[i] !== t_exp[i]) $display("[TB] FAIL stall_order_%0d: got tag=%0d data=%h want tag=%0d data=%h", i, got_tag[i], got_data[i], i + 8, t_exp[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_stall_toggle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
